slot_select_gen: RTL and testbench
==================================

Name: slot_select_gen

Overview:
- Multi-slot generator for Apple II peripheral-slot select strobes. Successor to the single-slot slot bundle.
- Decodes each bus cycle and drives per-slot IOSELECT, DEVSELECT and IOSTROBE (active-low), plus the card ID of the selected slot.
- Tracks $C800-$CFFF expansion-ROM ownership with a sequential owner register.
- Sits between the bus front-end and the card instances; one output lane per slot.

Parameters:
- NUM_SLOTS, 8, number of slot lanes (slots 0..NUM_SLOTS-1); legal range 1..8.
- SLOT_EN_MASK, 8'hFE, bit n=1 enables decode for slot n; slot 0 has no ROM space, so its IOSELECT never asserts.
- CLEAR_ON_CFFF_WRITE_ONLY, 0, 1 = only writes to $CFFF release ownership; 0 = reads or writes release it.

Ports:
- clk_logic_i  in  1  logic clock.
- system_reset_i  in  1  synchronous, active-high reset.
- addr_i  in  16  bus address; sampled on cycle_start_i.
- rw_n_i  in  1  1 = read, 0 = write; sampled on cycle_start_i.
- cycle_start_i  in  1  one-clock pulse; address/rw valid.
- cycle_end_i  in  1  one-clock pulse; end of bus cycle.
- card_id_i  in  8*NUM_SLOTS  card ID per slot; slot n occupies bits [8n+7:8n].
- ioselect_n_o  out  NUM_SLOTS  $Cn00-$CnFF select per slot.
- devselect_n_o  out  NUM_SLOTS  $C0(8+n)0-$C0(8+n)F select per slot.
- iostrobe_n_o  out  NUM_SLOTS  $C800-$CFFF select, owner slot only.
- active_valid_o  out  1  some select is asserted this cycle.
- active_slot_o  out  3  slot number of the asserted select.
- active_card_id_o  out  8  card_id_i of active_slot_o; 0 when none.
- c8_owner_o  out  3  current $C800 owner; 0 = none.

Behaviour:
- Reset (sync, active-high): all *_n outputs = all ones, active_valid_o=0, active_slot_o=0, active_card_id_o=0, c8_owner_o=0.
- Reset overrides everything, including mid-cycle; selects drop on the next edge.
- FSM has two states, IDLE and ACTIVE.
- IDLE + cycle_start_i: register the decode; go to ACTIVE. Selects are asserted the clock after cycle_start_i (latency 1).
- ACTIVE: outputs held stable regardless of addr_i changes.
- ACTIVE + cycle_end_i: all selects deassert the next clock; go to IDLE.
- cycle_start_i and cycle_end_i in the same clock while ACTIVE: the new decode replaces the old one; stay ACTIVE with no idle gap.
- cycle_end_i while IDLE is ignored. cycle_start_i while ACTIVE (without end) restarts the decode.
- Decode (slot n enabled, n<NUM_SLOTS):
  - DEVSELECT: addr[15:4] == 12'hC08 + n.
  - IOSELECT: addr[15:8] == 8'hC0 + n, with n >= 1.
  - IOSTROBE: addr[15:11] == 5'b11001 and c8_owner_o == n, with n != 0.
- Slots that are disabled or out of range never assert.
- At most one bit across the three vectors is low at a time.
- Ownership:
  - Updated at the registered decode edge (same edge the selects assert).
  - IOSELECT access to slot n: owner <= n.
  - Access to $CFFF (subject to CLEAR_ON_CFFF_WRITE_ONLY): IOSTROBE is asserted for that cycle using the pre-clear owner; owner <= 0 on the same edge the selects register. The clear is internal; c8_owner_o shows 0 from that edge onward, while iostrobe_n_o uses the latched pre-clear owner.
  - Accesses to disabled slots do not change the owner.
- active_card_id_o is registered alongside the selects.

Optional Feature:
- Macro: SLOT_SELECT_INTCXROM_EN.
- Defined: adds Apple IIe soft-switch flags, both reset to 0. Flags update on writes at cycle_start_i.
  - intcxrom: $C006 write clears, $C007 write sets.
  - slotc3rom: $C00A write clears, $C00B write sets.
  - intcxrom=1 suppresses all IOSELECT and IOSTROBE; ownership is not updated, but $CFFF still clears it.
  - slotc3rom=0 suppresses slot-3 IOSELECT and blocks slot-3 ownership claims.
- Undefined: no flags; slot ROM space is always external.

Test Plan:
- Reset, then cycle at $C600 read -> next clock ioselect_n_o=8'hBF, active_slot_o=6, active_card_id_o=card_id of slot 6, c8_owner_o=6; cycle_end_i -> all ones the next clock.
- After owning slot 6, access $C900 -> iostrobe_n_o=8'hBF; access $CFFF -> iostrobe_n_o=8'hBF that cycle, c8_owner_o=0 afterward; a following $C900 access asserts no select.
- $C0D3 access -> devselect_n_o=8'hDF (slot 5); owner unchanged.
- SLOT_EN_MASK=8'hF6, access $C300 -> no select, active_valid_o=0, owner unchanged.
- Back-to-back cycles with start and end in the same clock ($C100 then $C200) -> ioselect_n_o goes 8'hFD -> 8'hFB with no all-ones gap; system_reset_i asserted mid-ACTIVE -> all ones the next clock.
- With SLOT_SELECT_INTCXROM_EN: write $C007, then access $C600 -> no IOSELECT; write $C006 -> $C600 selects again; slot-3 ROM stays suppressed until a $C00B write.

Source files
------------

// File: rtl/slot_select_gen.sv
// -----------------------------------------------------------------------------
// slot_select_gen
//
// Purpose:
//   Multi-slot generator for the Apple II peripheral-slot select strobes.
//   Each bus cycle is decoded once, when cycle_start_i pulses. The result is
//   registered and held until cycle_end_i, or until the next cycle_start_i.
//   The block drives per-slot IOSELECT, DEVSELECT and IOSTROBE (all
//   active-low), and reports which slot is active together with that slot's
//   card ID. It also tracks which slot currently owns the shared
//   $C800-$CFFF expansion-ROM window.
//
// Optional feature (macro SLOT_SELECT_INTCXROM_EN):
//   Adds the Apple IIe INTCXROM and SLOTC3ROM soft-switch flags. Both flags
//   reset to 0.
//     - INTCXROM=1 hides all slot ROM: no IOSELECT, no IOSTROBE and no
//       ownership claims. A $CFFF access still clears the owner.
//     - SLOTC3ROM=0 hides the slot-3 ROM and blocks slot 3 from claiming
//       ownership.
//   Without the macro, slot ROM space is always external.
//
// Ports:
//   clk_logic_i       logic clock
//   system_reset_i    synchronous, active-high reset
//   addr_i            bus address, sampled on cycle_start_i
//   rw_n_i            1 = read, 0 = write, sampled on cycle_start_i
//   cycle_start_i     one-clock pulse: address and rw are valid
//   cycle_end_i       one-clock pulse: end of the bus cycle
//   card_id_i         8-bit card ID per slot; slot n occupies bits [8n+7:8n]
//   ioselect_n_o      $Cn00-$CnFF select, one bit per slot
//   devselect_n_o     $C0(8+n)0-$C0(8+n)F select, one bit per slot
//   iostrobe_n_o      $C800-$CFFF select; only the owner slot's bit asserts
//   active_valid_o    some select is asserted
//   active_slot_o     slot number of the asserted select (0 when none)
//   active_card_id_o  card ID of active_slot_o (0 when none)
//   c8_owner_o        current $C800 owner (0 = none)
// -----------------------------------------------------------------------------
module slot_select_gen #(
  parameter int         NUM_SLOTS                = 8,
  parameter logic [7:0] SLOT_EN_MASK             = 8'hFE,
  parameter bit         CLEAR_ON_CFFF_WRITE_ONLY = 1'b0
) (
  input  logic                   clk_logic_i,
  input  logic                   system_reset_i,
  input  logic [15:0]            addr_i,
  input  logic                   rw_n_i,
  input  logic                   cycle_start_i,
  input  logic                   cycle_end_i,
  input  logic [8*NUM_SLOTS-1:0] card_id_i,
  output logic [NUM_SLOTS-1:0]   ioselect_n_o,
  output logic [NUM_SLOTS-1:0]   devselect_n_o,
  output logic [NUM_SLOTS-1:0]   iostrobe_n_o,
  output logic                   active_valid_o,
  output logic [2:0]             active_slot_o,
  output logic [7:0]             active_card_id_o,
  output logic [2:0]             c8_owner_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] ioselect_n_q, ioselect_n_d;
  logic [NUM_SLOTS-1:0] devselect_n_q, devselect_n_d;
  logic [NUM_SLOTS-1:0] iostrobe_n_q, iostrobe_n_d;
  logic                 active_valid_q, active_valid_d;
  logic [2:0]           active_slot_q, active_slot_d;
  logic [7:0]           active_card_id_q, active_card_id_d;
  logic [2:0]           c8_owner_q, c8_owner_d;

  // Per-slot hit vectors for the address currently on the bus.
  logic [NUM_SLOTS-1:0] dev_hit_s;
  logic [NUM_SLOTS-1:0] io_hit_s;
  logic [NUM_SLOTS-1:0] strb_hit_s;
  logic [2:0]           hit_slot_s;
  logic [7:0]           hit_card_id_s;
  logic                 hit_any_s;
  logic                 cfff_clear_s;
  logic                 rom_ok_s;   // slot ROM space is external (not internal CX ROM)
  logic                 c3_ok_s;    // slot-3 ROM space is external

`ifdef SLOT_SELECT_INTCXROM_EN
  logic intcxrom_q, intcxrom_d;
  logic slotc3rom_q, slotc3rom_d;

  // Soft-switch flag update on writes to $C006/$C007/$C00A/$C00B.
  always_comb begin
    intcxrom_d  = intcxrom_q;
    slotc3rom_d = slotc3rom_q;
    if (cycle_start_i && !rw_n_i) begin
      case (addr_i)
        16'hC006: intcxrom_d  = 1'b0;
        16'hC007: intcxrom_d  = 1'b1;
        16'hC00A: slotc3rom_d = 1'b0;
        16'hC00B: slotc3rom_d = 1'b1;
        default: begin
          intcxrom_d  = intcxrom_q;
          slotc3rom_d = slotc3rom_q;
        end
      endcase
    end else begin
      intcxrom_d  = intcxrom_q;
      slotc3rom_d = slotc3rom_q;
    end
  end

  // Soft-switch flag registers.
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      intcxrom_q  <= 1'b0;
      slotc3rom_q <= 1'b0;
    end else begin
      intcxrom_q  <= intcxrom_d;
      slotc3rom_q <= slotc3rom_d;
    end
  end

  assign rom_ok_s = ~intcxrom_q;
  assign c3_ok_s  = slotc3rom_q;
`else
  assign rom_ok_s = 1'b1;
  assign c3_ok_s  = 1'b1;
`endif

  // Address decode. The three address windows are disjoint, so at most one
  // bit across dev/io/strb can be set at once.
  always_comb begin
    dev_hit_s     = '0;
    io_hit_s      = '0;
    strb_hit_s    = '0;
    hit_slot_s    = 3'd0;
    hit_card_id_s = 8'h00;
    for (int n = 0; n < NUM_SLOTS; n++) begin
      dev_hit_s[n]  = SLOT_EN_MASK[n] && (addr_i[15:4] == (12'hC08 + 12'(n)));
      // Slot 0 has no ROM space, so it never gets IOSELECT or IOSTROBE.
      io_hit_s[n]   = SLOT_EN_MASK[n] && (n != 0) && rom_ok_s &&
                      ((n != 3) || c3_ok_s) &&
                      (addr_i[15:8] == (8'hC0 + 8'(n)));
      // IOSTROBE uses the owner as it stands before this cycle's update.
      strb_hit_s[n] = SLOT_EN_MASK[n] && (n != 0) && rom_ok_s &&
                      (addr_i[15:11] == 5'b11001) && (c8_owner_q == 3'(n));
      hit_slot_s    = (dev_hit_s[n] || io_hit_s[n] || strb_hit_s[n]) ?
                      3'(n) : hit_slot_s;
      hit_card_id_s = (dev_hit_s[n] || io_hit_s[n] || strb_hit_s[n]) ?
                      card_id_i[8*n +: 8] : hit_card_id_s;
    end
    hit_any_s    = |{dev_hit_s, io_hit_s, strb_hit_s};
    cfff_clear_s = (addr_i == 16'hCFFF) && (!rw_n_i || !CLEAR_ON_CFFF_WRITE_ONLY);
  end

  // $C800 owner: a $CFFF access clears it, an IOSELECT hit claims it.
  // Both take effect on the decode edge.
  always_comb begin
    c8_owner_d = c8_owner_q;
    if (cycle_start_i) begin
      if (cfff_clear_s) begin
        c8_owner_d = 3'd0;
      end else if (|io_hit_s) begin
        c8_owner_d = hit_slot_s;
      end else begin
        c8_owner_d = c8_owner_q;
      end
    end else begin
      c8_owner_d = c8_owner_q;
    end
  end

  // Cycle FSM next state. A start always loads a fresh decode, even while
  // ACTIVE and even with a coincident end; otherwise an end in ACTIVE releases
  // all selects.
  always_comb begin
    state_d          = state_q;
    ioselect_n_d     = ioselect_n_q;
    devselect_n_d    = devselect_n_q;
    iostrobe_n_d     = iostrobe_n_q;
    active_valid_d   = active_valid_q;
    active_slot_d    = active_slot_q;
    active_card_id_d = active_card_id_q;
    if (cycle_start_i) begin
      state_d          = ACTIVE;
      ioselect_n_d     = ~io_hit_s;
      devselect_n_d    = ~dev_hit_s;
      iostrobe_n_d     = ~strb_hit_s;
      active_valid_d   = hit_any_s;
      active_slot_d    = hit_slot_s;
      active_card_id_d = hit_card_id_s;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACTIVE: begin
          if (cycle_end_i) begin
            state_d          = IDLE;
            ioselect_n_d     = '1;
            devselect_n_d    = '1;
            iostrobe_n_d     = '1;
            active_valid_d   = 1'b0;
            active_slot_d    = 3'd0;
            active_card_id_d = 8'h00;
          end else begin
            state_d = ACTIVE;
          end
        end
        default: begin
          state_d          = IDLE;
          ioselect_n_d     = '1;
          devselect_n_d    = '1;
          iostrobe_n_d     = '1;
          active_valid_d   = 1'b0;
          active_slot_d    = 3'd0;
          active_card_id_d = 8'h00;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      state_q          <= IDLE;
      ioselect_n_q     <= '1;
      devselect_n_q    <= '1;
      iostrobe_n_q     <= '1;
      active_valid_q   <= 1'b0;
      active_slot_q    <= 3'd0;
      active_card_id_q <= 8'h00;
      c8_owner_q       <= 3'd0;
    end else begin
      state_q          <= state_d;
      ioselect_n_q     <= ioselect_n_d;
      devselect_n_q    <= devselect_n_d;
      iostrobe_n_q     <= iostrobe_n_d;
      active_valid_q   <= active_valid_d;
      active_slot_q    <= active_slot_d;
      active_card_id_q <= active_card_id_d;
      c8_owner_q       <= c8_owner_d;
    end
  end

  assign ioselect_n_o     = ioselect_n_q;
  assign devselect_n_o    = devselect_n_q;
  assign iostrobe_n_o     = iostrobe_n_q;
  assign active_valid_o   = active_valid_q;
  assign active_slot_o    = active_slot_q;
  assign active_card_id_o = active_card_id_q;
  assign c8_owner_o       = c8_owner_q;

endmodule

// File: tb/tb_slot_select_gen.sv
// Bench for slot_select_gen.
// Instance A uses the default parameters.
// Instance B uses mask 8'hF6 and releases the $C800 owner only on $CFFF writes.
// A behavioural model predicts both instances on every clock.
module tb_slot_select_gen;

  logic        clk = 1'b0;
  logic        rst, start, cend, rw;
  logic [15:0] addr;
  logic [63:0] card_id;

  logic [7:0] io_a, dev_a, st_a, id_a, io_b, dev_b, st_b, id_b;
  logic       valid_a, valid_b;
  logic [2:0] slot_a, own_a, slot_b, own_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slot_select_gen #(.NUM_SLOTS(8), .SLOT_EN_MASK(8'hFE), .CLEAR_ON_CFFF_WRITE_ONLY(1'b0)) u_a (
    .clk_logic_i(clk), .system_reset_i(rst), .addr_i(addr), .rw_n_i(rw),
    .cycle_start_i(start), .cycle_end_i(cend), .card_id_i(card_id),
    .ioselect_n_o(io_a), .devselect_n_o(dev_a), .iostrobe_n_o(st_a),
    .active_valid_o(valid_a), .active_slot_o(slot_a), .active_card_id_o(id_a),
    .c8_owner_o(own_a));

  slot_select_gen #(.NUM_SLOTS(8), .SLOT_EN_MASK(8'hF6), .CLEAR_ON_CFFF_WRITE_ONLY(1'b1)) u_b (
    .clk_logic_i(clk), .system_reset_i(rst), .addr_i(addr), .rw_n_i(rw),
    .cycle_start_i(start), .cycle_end_i(cend), .card_id_i(card_id),
    .ioselect_n_o(io_b), .devselect_n_o(dev_b), .iostrobe_n_o(st_b),
    .active_valid_o(valid_b), .active_slot_o(slot_b), .active_card_id_o(id_b),
    .c8_owner_o(own_b));

  // ---------------- behavioural model ----------------
  logic [7:0] mask  [2] = '{8'hFE, 8'hF6};
  bit         clrwo [2] = '{1'b0, 1'b1};
  logic [7:0] m_io[2], m_dev[2], m_st[2], m_id[2];
  logic       m_valid[2];
  logic [2:0] m_slot[2], m_own[2];
  bit         m_icx[2], m_c3[2];
  bit         m_ready = 1'b0;

  task automatic model_clear(input int k);
    m_io[k] = 8'hFF; m_dev[k] = 8'hFF; m_st[k] = 8'hFF;
    m_valid[k] = 1'b0; m_slot[k] = 3'd0; m_id[k] = 8'h00;
  endtask

  // kind: 0 none, 1 devselect, 2 ioselect, 3 iostrobe
  task automatic model_cycle(input int k);
    int kind = 0;
    int n = 0;
    if (addr >= 16'hC080 && addr <= 16'hC0FF) begin
      n = int'(addr[7:4]) - 8;
      if (mask[k][n]) kind = 1;
    end else if (addr >= 16'hC100 && addr <= 16'hC7FF) begin
      n = int'(addr[11:8]);
      if (mask[k][n] && !m_icx[k] && (n != 3 || m_c3[k])) kind = 2;
    end else if (addr >= 16'hC800 && addr <= 16'hCFFF) begin
      n = int'(m_own[k]);
      if (n != 0 && !m_icx[k]) kind = 3;
    end
    model_clear(k);
    if (kind == 1) m_dev[k][n] = 1'b0;
    if (kind == 2) m_io[k][n]  = 1'b0;
    if (kind == 3) m_st[k][n]  = 1'b0;
    if (kind != 0) begin
      m_valid[k] = 1'b1;
      m_slot[k]  = 3'(n);
      m_id[k]    = card_id[8*n +: 8];
    end
    if (addr == 16'hCFFF && (!rw || !clrwo[k])) m_own[k] = 3'd0;
    else if (kind == 2) m_own[k] = 3'(n);
`ifdef SLOT_SELECT_INTCXROM_EN
    if (!rw) begin
      if (addr == 16'hC006) m_icx[k] = 1'b0;
      if (addr == 16'hC007) m_icx[k] = 1'b1;
      if (addr == 16'hC00A) m_c3[k]  = 1'b0;
      if (addr == 16'hC00B) m_c3[k]  = 1'b1;
    end
`endif
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_clear(k);
        m_own[k] = 3'd0;
        m_icx[k] = 1'b0;
`ifdef SLOT_SELECT_INTCXROM_EN
        m_c3[k] = 1'b0;
`else
        m_c3[k] = 1'b1;
`endif
      end else if (start) begin
        model_cycle(k);
      end else if (cend) begin
        model_clear(k);
      end
    end
    m_ready = 1'b1;
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("io_a", io_a, m_io[0]);        check("io_b", io_b, m_io[1]);
      check("dev_a", dev_a, m_dev[0]);     check("dev_b", dev_b, m_dev[1]);
      check("st_a", st_a, m_st[0]);        check("st_b", st_b, m_st[1]);
      check("valid_a", 8'(valid_a), 8'(m_valid[0]));
      check("valid_b", 8'(valid_b), 8'(m_valid[1]));
      check("slot_a", 8'(slot_a), 8'(m_slot[0]));
      check("slot_b", 8'(slot_b), 8'(m_slot[1]));
      check("id_a", id_a, m_id[0]);        check("id_b", id_b, m_id[1]);
      check("own_a", 8'(own_a), 8'(m_own[0]));
      check("own_b", 8'(own_b), 8'(m_own[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [15:0] a, input logic r, input logic e);
    addr = a; rw = r; start = 1'b1; cend = e;
    @(negedge clk);
    start = 1'b0; cend = 1'b0;
  endtask

  task automatic fin();
    cend = 1'b1;
    @(negedge clk);
    cend = 1'b0;
  endtask

  logic [15:0] table_addr [15] = '{16'hC080, 16'hC0F5, 16'hC0E0, 16'hC0B7, 16'hC400,
                                   16'hC500, 16'hC700, 16'hCA00, 16'hCFFE, 16'hC800,
                                   16'hC000, 16'hD000, 16'hC070, 16'hC300, 16'hC7FF};

  initial begin
    rst = 1'b1; start = 1'b0; cend = 1'b0; rw = 1'b1; addr = 16'h0000;
    for (int i = 0; i < 8; i++) card_id[8*i +: 8] = 8'hA0 + 8'(i);
    repeat (2) @(negedge clk);
    check("rst_io", io_a, 8'hFF);
    check("rst_valid", 8'(valid_a), 8'h00);
    check("rst_own", 8'(own_a), 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // $C600 read: slot 6 selected, owns $C800
    cyc(16'hC600, 1'b1, 1'b0);
    check("c600_io", io_a, 8'hBF);
    check("c600_slot", 8'(slot_a), 8'h06);
    check("c600_id", id_a, 8'hA6);
    check("c600_own", 8'(own_a), 8'h06);
    check("c600_model_own", 8'(m_own[0]), 8'h06);
    addr = 16'h0000;
    @(negedge clk);
    check("hold_io", io_a, 8'hBF);
    fin();
    check("end_io", io_a, 8'hFF);
    check("end_valid", 8'(valid_a), 8'h00);

    cyc(16'hC900, 1'b1, 1'b0);
    check("c900_st", st_a, 8'hBF);
    fin();
    cyc(16'hCFFF, 1'b1, 1'b0);
    check("cfff_st", st_a, 8'hBF);
    check("cfff_own", 8'(own_a), 8'h00);
    check("cfff_rd_own_b", 8'(own_b), 8'h06);
    fin();
    cyc(16'hC900, 1'b1, 1'b0);
    check("c900b_st", st_a, 8'hFF);
    check("c900b_valid", 8'(valid_a), 8'h00);
    check("c900b_st_b", st_b, 8'hBF);
    fin();
    cyc(16'hCFFF, 1'b0, 1'b0);
    check("cfff_wr_own_b", 8'(own_b), 8'h00);
    fin();

    cyc(16'hC200, 1'b1, 1'b0);
    fin();
    cyc(16'hC0D3, 1'b1, 1'b0);
    check("c0d3_dev", dev_a, 8'hDF);
    check("c0d3_slot", 8'(slot_a), 8'h05);
    check("c0d3_own", 8'(own_a), 8'h02);
    fin();

    cyc(16'hC300, 1'b1, 1'b0);
    check("c300_io_b", io_b, 8'hFF);
    check("c300_valid_b", 8'(valid_b), 8'h00);
    check("c300_own_b", 8'(own_b), 8'h02);
    fin();

    // back-to-back, restart without end, then mid-cycle reset
    cyc(16'hC100, 1'b1, 1'b0);
    check("b2b1_io", io_a, 8'hFD);
    cyc(16'hC200, 1'b1, 1'b1);
    check("b2b2_io", io_a, 8'hFB);
    check("b2b2_valid", 8'(valid_a), 8'h01);
    cyc(16'hC0A0, 1'b1, 1'b0);
    check("restart_dev", dev_a, 8'hFB);
    check("restart_io", io_a, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dev", dev_a, 8'hFF);
    check("midrst_own", 8'(own_a), 8'h00);
    rst = 1'b0;
    fin();   // end while idle: ignored

    for (int i = 0; i < 15; i++) begin
      cyc(table_addr[i], 1'(i % 2), 1'b0);
      fin();
      @(negedge clk);
    end

`ifdef SLOT_SELECT_INTCXROM_EN
    cyc(16'hC007, 1'b0, 1'b0); fin();
    cyc(16'hC600, 1'b1, 1'b0);
    check("icx_io", io_a, 8'hFF);
    fin();
    cyc(16'hC006, 1'b0, 1'b0); fin();
    cyc(16'hC600, 1'b1, 1'b0);
    check("icx_off_io", io_a, 8'hBF);
    check("icx_off_own", 8'(own_a), 8'h06);
    fin();
    cyc(16'hC007, 1'b0, 1'b0); fin();
    cyc(16'hCFFF, 1'b1, 1'b0);
    check("icx_cfff_st", st_a, 8'hFF);
    check("icx_cfff_own", 8'(own_a), 8'h00);
    fin();
    cyc(16'hC006, 1'b0, 1'b0); fin();
    cyc(16'hC300, 1'b1, 1'b0);
    check("c3off_io", io_a, 8'hFF);
    fin();
    cyc(16'hC00B, 1'b0, 1'b0); fin();
    cyc(16'hC300, 1'b1, 1'b0);
    check("c3on_io", io_a, 8'hF7);
    check("c3on_own", 8'(own_a), 8'h03);
    fin();
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
